control_sequencer: RTL and testbench

Multi-cycle control unit for the single-bus datapath. Steps through fetch (T0–T2) and per-opcode execute steps (T3–T7) and drives every datapath strobe. That includes the register-file select controls Gra/Grb/Grc, Rin, Rout and BAout, which the select-and-encode logic turns into the 16-bit register in/out enables. It sits between the IR and the datapath. It is the producer of the controls that the register select logic consumes.

---
 rtl/control_pkg.sv | 47 ++++
 rtl/opcode_class_decode.sv | 30 +++
 rtl/control_sequencer.sv | 151 +++++++++++++++
 tb/tb_control_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared opcodes, ALU codes, step numbers and state classes for the control sequencer.
//   No ports; imported by opcode_class_decode and control_sequencer.
package control_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;
    localparam logic [2:0] T7 = 3'd7;

    // Bit positions in the one-hot instruction class vector.
    localparam int C_ALU_RR  = 0;
    localparam int C_ALU_IMM = 1;
    localparam int C_LDI     = 2;
    localparam int C_LD      = 3;
    localparam int C_ST      = 4;
    localparam int C_BR      = 5;
    localparam int C_JR      = 6;
    localparam int C_NOP     = 7;
    localparam int C_HALT    = 8;

    typedef enum logic [1:0] {S_RESET, S_STEP, S_HALT} state_t;

endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode: maps a 5-bit opcode to a one-hot instruction class and its ALU operation.
//   opcode   in  5  IR[31:27]
//   op_class out 9  one-hot class, indexed by the C_* positions in control_pkg
//   alu_op   out 4  ALU operation used by the class's compute step
module opcode_class_decode
    import control_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [8:0] op_class,
    output logic [3:0] alu_op
);

    always_comb begin
        op_class            = '0;
        op_class[C_ALU_RR]  = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
        op_class[C_ALU_IMM] = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
        op_class[C_LDI]     = opcode == OP_LDI;
        op_class[C_LD]      = opcode == OP_LD;
        op_class[C_ST]      = opcode == OP_ST;
        op_class[C_BR]      = opcode == OP_BR;
        op_class[C_JR]      = opcode == OP_JR;
        op_class[C_HALT]    = opcode == OP_HALT;
        // nop and every undefined opcode fall into the nop class
        op_class[C_NOP]     = op_class == '0;
        alu_op = (opcode == OP_SUB)                  ? ALU_SUB :
                 (opcode inside {OP_AND, OP_ANDI})   ? ALU_AND :
                 (opcode inside {OP_OR, OP_ORI})     ? ALU_OR  : ALU_ADD;
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/execute control unit driving every single-bus datapath strobe.
//   clk, reset (sync, active-high)  ; IR[31:0] instruction, CON branch condition
//   Gra/Grb/Grc, Rin/Rout/BAout     register-file selects and enables
//   Cout, PCout/PCin/IncPC, MARin/MDRin/MDRout, Read/Write, IRin/Yin/Zin/Zlowout/CONin
//   alu_op[3:0], Run
module control_sequencer
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        CONin,
    output logic [3:0]  alu_op,
    output logic        Run
);

    state_t     state, state_n;
    logic [2:0] step, step_n;
    logic [8:0] cls;
    logic [3:0] dec_alu;
    logic       last;
    logic       ir_unused;

    assign ir_unused = ^IR[26:0];

    opcode_class_decode u_dec (
        .opcode   (IR[31:27]),
        .op_class (cls),
        .alu_op   (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RESET;
            step  <= T0;
        end else begin
            state <= state_n;
            step  <= step_n;
        end
    end

    // Final step of each instruction class; T7 always ends an instruction.
    assign last = (step == T2 && cls[C_NOP]) ||
                  (step == T3 && cls[C_JR]) ||
                  (step == T5 && (cls[C_ALU_RR] || cls[C_ALU_IMM] || cls[C_LDI])) ||
                  (step == T6 && cls[C_BR]) ||
                  (step == T7);

    always_comb begin
        state_n = state;
        step_n  = step;
        case (state)
            S_RESET: begin
                state_n = S_STEP;
                step_n  = T0;
            end
            S_STEP: begin
                if (step == T2 && cls[C_HALT]) begin
                    state_n = S_HALT;
                    step_n  = T0;
                end else begin
                    step_n  = last ? T0 : step + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
         Read, Write, IRin, Yin, Zin, Zlowout, CONin} = '0;
        alu_op = ALU_ADD;
        Run    = state == S_STEP;
        if (state == S_STEP) begin
            case (step)
                T0: {PCout, MARin, IncPC, Zin} = '1;
                T1: {Zlowout, PCin, Read, MDRin} = '1;
                T2: {MDRout, IRin} = '1;
                T3: begin
                    if (cls[C_BR] || cls[C_JR]) begin
                        {Gra, Rout} = '1;
                        CONin = cls[C_BR];
                        PCin  = cls[C_JR];
                    end else if (cls[C_ALU_RR] || cls[C_ALU_IMM]) begin
                        {Grb, Rout, Yin} = '1;
                    end else if (cls[C_LDI] || cls[C_LD] || cls[C_ST]) begin
                        {Grb, BAout, Yin} = '1;
                    end
                end
                T4: begin
                    if (cls[C_BR]) begin
                        {PCout, Yin} = '1;
                    end else if (cls[C_ALU_RR]) begin
                        {Grc, Rout, Zin} = '1;
                        alu_op = dec_alu;
                    end else if (cls[C_ALU_IMM]) begin
                        {Cout, Zin} = '1;
                        alu_op = dec_alu;
                    end else if (cls[C_LDI] || cls[C_LD] || cls[C_ST]) begin
                        {Cout, Zin} = '1;
                    end
                end
                T5: begin
                    if (cls[C_BR])
                        {Cout, Zin} = '1;
                    else if (cls[C_ALU_RR] || cls[C_ALU_IMM] || cls[C_LDI])
                        {Zlowout, Gra, Rin} = '1;
                    else if (cls[C_LD] || cls[C_ST])
                        {Zlowout, MARin} = '1;
                end
                T6: begin
                    if (cls[C_LD]) begin
                        {Read, MDRin} = '1;
                    end else if (cls[C_ST]) begin
                        {Gra, Rout, MDRin} = '1;
                    end else if (cls[C_BR]) begin
                        Zlowout = 1'b1;
                        PCin    = CON;
                    end
                end
                default: begin
                    if (cls[C_LD])
                        {MDRout, Gra, Rin} = '1;
                    else if (cls[C_ST])
                        Write = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; expected per-cycle control words come from a per-opcode table model.
module tb_control_sequencer;

    typedef logic [24:0] word_t;

    localparam word_t GRA   = 25'd1 << 24;
    localparam word_t GRB   = 25'd1 << 23;
    localparam word_t GRC   = 25'd1 << 22;
    localparam word_t RIN   = 25'd1 << 21;
    localparam word_t ROUT  = 25'd1 << 20;
    localparam word_t BAOUT = 25'd1 << 19;
    localparam word_t COUT  = 25'd1 << 18;
    localparam word_t PCOUT = 25'd1 << 17;
    localparam word_t PCIN  = 25'd1 << 16;
    localparam word_t INCPC = 25'd1 << 15;
    localparam word_t MARIN = 25'd1 << 14;
    localparam word_t MDRIN = 25'd1 << 13;
    localparam word_t MDROUT= 25'd1 << 12;
    localparam word_t READ  = 25'd1 << 11;
    localparam word_t WRITE = 25'd1 << 10;
    localparam word_t IRIN  = 25'd1 << 9;
    localparam word_t YIN   = 25'd1 << 8;
    localparam word_t ZIN   = 25'd1 << 7;
    localparam word_t ZLOW  = 25'd1 << 6;
    localparam word_t CONIN = 25'd1 << 5;
    localparam word_t RUN   = 25'd1;

    logic clk = 0, reset, CON;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
    logic Read, Write, IRin, Yin, Zin, Zlowout, CONin, Run;
    logic [3:0] alu_op;
    word_t act;
    word_t exp_q[$];
    word_t seq[$];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    control_sequencer dut (
        .clk(clk), .reset(reset), .IR(IR), .CON(CON),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .CONin(CONin), .alu_op(alu_op), .Run(Run)
    );

    assign act = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                  Read, Write, IRin, Yin, Zin, Zlowout, CONin, alu_op, Run};

    function automatic word_t alu(input int op);
        return word_t'(op) << 1;
    endfunction

    // Reference: the instruction's full per-cycle control words, fetch included.
    task automatic build(input logic [4:0] op, input logic con);
        seq.delete();
        seq.push_back(PCOUT | MARIN | INCPC | ZIN | RUN);
        seq.push_back(ZLOW | PCIN | READ | MDRIN | RUN);
        seq.push_back(MDROUT | IRIN | RUN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                seq.push_back(GRB | ROUT | YIN | RUN);
                seq.push_back(GRC | ROUT | ZIN | alu(int'(op) - 3) | RUN);
                seq.push_back(ZLOW | GRA | RIN | RUN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                seq.push_back(GRB | ROUT | YIN | RUN);
                seq.push_back(COUT | ZIN | alu(op == 5'b01100 ? 0 : op == 5'b01101 ? 2 : 3) | RUN);
                seq.push_back(ZLOW | GRA | RIN | RUN);
            end
            5'b00001, 5'b00000, 5'b00010: begin
                seq.push_back(GRB | BAOUT | YIN | RUN);
                seq.push_back(COUT | ZIN | RUN);
                if (op == 5'b00001) begin
                    seq.push_back(ZLOW | GRA | RIN | RUN);
                end else begin
                    seq.push_back(ZLOW | MARIN | RUN);
                    seq.push_back(op == 5'b00000 ? (READ | MDRIN | RUN) : (GRA | ROUT | MDRIN | RUN));
                    seq.push_back(op == 5'b00000 ? (MDROUT | GRA | RIN | RUN) : (WRITE | RUN));
                end
            end
            5'b10010: begin
                seq.push_back(GRA | ROUT | CONIN | RUN);
                seq.push_back(PCOUT | YIN | RUN);
                seq.push_back(COUT | ZIN | RUN);
                seq.push_back(ZLOW | (con ? PCIN : '0) | RUN);
            end
            5'b10011: seq.push_back(GRA | ROUT | PCIN | RUN);
            default: ;
        endcase
    endtask

    // Runs one instruction; if cut >= 0, reset is raised during cycle index cut and the rest is dropped.
    task automatic drive(input logic [4:0] op, input logic con, input int cut);
        build(op, con);
        IR = {op, 27'($urandom)};
        for (int c = 0; c < seq.size(); c++) begin
            if (cut >= 0 && c > cut) break;
            exp_q.push_back(seq[c]);
            CON = (op == 5'b10010 && c == 6) ? con : 1'($urandom);
            reset = (c == cut);
            @(posedge clk); #1;
        end
        reset = 0;
    endtask

    task automatic idle(input int n, input logic rst);
        for (int c = 0; c < n; c++) begin
            exp_q.push_back('0);
            reset = rst;
            CON = 1'($urandom);
            @(posedge clk); #1;
        end
        reset = 0;
    endtask

    always @(negedge clk) begin
        word_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle %0d controls: got %h want %h", cyc, act, e);
            end
        end
    end

    initial begin
        logic [4:0] op;
        reset = 1;
        IR = '0;
        CON = 0;
        @(posedge clk); #1;
        idle(3, 1'b1);
        idle(1, 1'b0);
        drive(5'b00011, 1'b0, -1);
        drive(5'b00000, 1'b0, -1);
        drive(5'b00010, 1'b0, -1);
        drive(5'b10010, 1'b1, -1);
        drive(5'b10010, 1'b0, -1);
        drive(5'b11111, 1'b0, -1);
        drive(5'b00000, 1'b0, 5);
        idle(1, 1'b0);
        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom);
            if (op == 5'b11011) op = 5'b00110;
            drive(op, 1'($urandom), -1);
        end
        drive(5'b11011, 1'b0, -1);
        idle(20, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        drive(5'b10011, 1'b0, -1);
        drive(5'b01101, 1'b0, -1);
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
